// File: rtl/debounce_pkg.sv
// Shared defaults and the counter-width helper for the debounce_multi block.
package debounce_pkg;

    localparam int DEF_N_CH          = 4;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_LONG_CYCLES   = 1024;

    // Bits needed to hold any value from 0 up to maxVal inclusive.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
// Long-press hold counter is present only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_button,
    output logic o_debounced,
    output logic o_rise,
    output logic o_fall,
    output logic o_longPress
);

    localparam int CNT_W = cntWidth(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_badParams
        $error("debounce_chan: STABLE_CYCLES and LONG_CYCLES must both be >= 1");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_levelPrev;
    logic             r_rise;
    logic             r_fall;

    // Any return of the synchronised input to the current level restarts the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_cnt       <= '0;
            r_level     <= 1'b0;
            r_levelPrev <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_sync1     <= i_button;
            r_sync2     <= r_sync1;
            r_levelPrev <= r_level;
            r_rise      <= r_level & ~r_levelPrev;
            r_fall      <= ~r_level & r_levelPrev;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_debounced = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int HOLD_W = cntWidth(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;

    // Counting begins the cycle after rise and saturates, so each press pulses at most once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= r_level & r_levelPrev & (r_hold == HOLD_LAST);
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_levelPrev && (r_hold != HOLD_MAX)) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_longPress = r_long;
`else
    assign o_longPress = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer; each channel is an independent debounce_chan.
// Optional long-press detection is enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_button   (button[gi]),
            .o_debounced(debounced[gi]),
            .o_rise     (rise[gi]),
            .o_fall     (fall[gi]),
            .o_longPress(long_press[gi])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N_CH=4, STABLE_CYCLES=8, LONG_CYCLES=32).
// Long-press expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_debounce_multi;

    localparam int N_CH   = 4;
    localparam int STABLE = 8;
    localparam int LONG   = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] debounced;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] long_press;

    typedef struct {
        logic [N_CH-1:0] deb;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
        logic [N_CH-1:0] lng;
        int              step;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   stepCount  = 0;

    debounce_multi #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(STABLE),
        .LONG_CYCLES  (LONG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Drives one input pattern for n cycles. Step j is the j-th rising edge of the segment;
    // the flipped channels change level at step flipAt and pulse rise/fall at flipAt+1.
    task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] btn, input int n,
                                 input logic [N_CH-1:0] debStart, input logic [N_CH-1:0] flipMask,
                                 input int flipAt, input logic [N_CH-1:0] longMask, input int longAt);
        exp_t e;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            reset  = rst;
            button = btn;
            stepCount++;
            e.deb  = (flipAt > 0 && j >= flipAt) ? (debStart ^ flipMask) : debStart;
            e.rise = (flipAt > 0 && j == flipAt + 1) ? (flipMask & ~debStart) : '0;
            e.fall = (flipAt > 0 && j == flipAt + 1) ? (flipMask & debStart) : '0;
`ifdef DEBOUNCE_LONGPRESS_EN
            e.lng  = (longAt > 0 && j == longAt) ? longMask : '0;
`else
            e.lng  = '0;
`endif
            e.step = stepCount;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name, input logic [N_CH-1:0] act,
                               input logic [N_CH-1:0] want, input int step);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s at step %0d: got %b, expected %b", name, step, act, want);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("debounced", debounced, e.deb, e.step);
                checkOutput("rise", rise, e.rise, e.step);
                checkOutput("fall", fall, e.fall, e.step);
                checkOutput("long_press", long_press, e.lng, e.step);
            end
        end
    end

    initial begin : stimulus
        reset  = 1'b1;
        button = '0;

        $display("[TB] reset with all buttons high, then release");
        applyStimulus(1'b1, 4'b1111, 3, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b1111, 14, 4'b0000, 4'b1111, 10, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 12, 4'b1111, 4'b1111, 10, 4'b0000, 0);

        $display("[TB] clean press on ch0");
        applyStimulus(1'b0, 4'b0001, 12, 4'b0000, 4'b0001, 10, 4'b0000, 0);

        $display("[TB] bounce train then release on ch0");
        applyStimulus(1'b0, 4'b0001, 3, 4'b0001, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 3, 4'b0001, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0001, 3, 4'b0001, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 12, 4'b0001, 4'b0001, 10, 4'b0000, 0);

        $display("[TB] 7-cycle glitches on ch1");
        applyStimulus(1'b0, 4'b0010, 7, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0010, 7, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 12, 4'b0000, 4'b0000, 0, 4'b0000, 0);

        $display("[TB] reset mid-count and while high on ch2");
        applyStimulus(1'b0, 4'b0100, 7, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b1, 4'b0100, 2, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0100, 12, 4'b0000, 4'b0100, 10, 4'b0000, 0);
        applyStimulus(1'b1, 4'b0100, 2, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0100, 12, 4'b0000, 4'b0100, 10, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 12, 4'b0100, 4'b0100, 10, 4'b0000, 0);

        $display("[TB] long hold and short hold on ch3");
        applyStimulus(1'b0, 4'b1000, 51, 4'b0000, 4'b1000, 10, 4'b1000, 43);
        applyStimulus(1'b0, 4'b0000, 12, 4'b1000, 4'b1000, 10, 4'b0000, 0);
        applyStimulus(1'b0, 4'b1000, 31, 4'b0000, 4'b1000, 10, 4'b0000, 0);
        applyStimulus(1'b0, 4'b0000, 12, 4'b1000, 4'b1000, 10, 4'b0000, 0);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
